// File: rtl/shared_counter_arbiter_pkg.sv
// Shared definitions for the shared-counter arbiter: data width, opcodes and FSM states.
package shared_counter_pkg;

    localparam int WIDTH = 9;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WR_HI = 2'b01,
        WR_LO = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shared_counter_arbiter_if.sv
// Bundle of the two requester ports, status outputs and the counter write port.
interface shared_counter_arbiter_if #(
    parameter int WIDTH = shared_counter_pkg::WIDTH
);
    logic             req0;
    logic [1:0]       op0;
    logic [WIDTH-1:0] operand0;
    logic             ack0;
    logic             req1;
    logic [1:0]       op1;
    logic [WIDTH-1:0] operand1;
    logic             ack1;
    logic             ovf;
    logic             busy;
    logic             owner;
    logic [WIDTH-1:0] cnt_value;
    logic [WIDTH-1:0] cnt_wrdata;
    logic             cnt_wr;

    // Arbiter side
    modport slave (
        input  req0, op0, operand0, req1, op1, operand1, cnt_value,
        output ack0, ack1, ovf, busy, owner, cnt_wrdata, cnt_wr
    );

    // Requesters and counter side
    modport master (
        output req0, op0, operand0, req1, op1, operand1, cnt_value,
        input  ack0, ack1, ovf, busy, owner, cnt_wrdata, cnt_wr
    );
endinterface

// File: rtl/shared_counter_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; prio names the requester that wins a tie.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt_valid,
    output logic gnt_idx
);
    assign gnt_valid = req0 | req1;
    assign gnt_idx   = (req0 & req1) ? prio : req1;
endmodule

// File: rtl/shared_counter_arbiter.sv
// Round-robin sequencer that performs read-modify-write operations on the shared counter
// for two requesters, using the counter's pulsed wr/wrdata protocol.
module shared_counter_arbiter
    import shared_counter_pkg::*;
#(
    parameter int WIDTH    = shared_counter_pkg::WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     nrst,
    shared_counter_arbiter_if.slave  bus
);
    state_t           state_reg, state_next;
    logic             prio_reg;
    logic             owner_reg;
    logic             cnt_wr_reg;
    logic             ack0_reg, ack1_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] wrdata_reg;

    logic             gnt_valid, gnt_idx;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_operand;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] result;
    logic             ovf_calc;

    rr_arb2 u_arb (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .prio      (prio_reg),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign sel_op      = gnt_idx ? bus.op1 : bus.op0;
    assign sel_operand = gnt_idx ? bus.operand1 : bus.operand0;

    // cnt_value is stable at the grant edge since this block is the counter's only writer
    assign sum    = {1'b0, bus.cnt_value} + {1'b0, sel_operand};
    assign diff   = bus.cnt_value - sel_operand;
    assign borrow = sel_operand > bus.cnt_value;

    always_comb begin
        result   = '0;
        ovf_calc = 1'b0;
        case (sel_op)
            OP_LOAD: result = sel_operand;
            OP_ADD: begin
                ovf_calc = sum[WIDTH];
                result   = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                ovf_calc = borrow;
                result   = (SATURATE && borrow) ? '0 : diff;
            end
            OP_CLR:  result = '0;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gnt_valid) state_next = WR_HI;
            WR_HI:   state_next = WR_LO;
            WR_LO:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            prio_reg   <= 1'b0;
            owner_reg  <= 1'b0;
            cnt_wr_reg <= 1'b0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            wrdata_reg <= '0;
        end else begin
            cnt_wr_reg <= 1'b0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_reg  <= gnt_idx;
                        wrdata_reg <= result;
                        ovf_reg    <= ovf_calc;
                        cnt_wr_reg <= 1'b1;
                    end
                end
                // Counter commits on this edge, so the ack lands with the new value visible
                WR_LO: begin
                    ack0_reg <= ~owner_reg;
                    ack1_reg <= owner_reg;
                end
                DONE:    prio_reg <= ~owner_reg;
                default: ;
            endcase
        end
    end

    assign bus.cnt_wr     = cnt_wr_reg;
    assign bus.cnt_wrdata = wrdata_reg;
    assign bus.ack0       = ack0_reg;
    assign bus.ack1       = ack1_reg;
    assign bus.ovf        = ovf_reg & (state_reg == DONE);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.owner      = owner_reg;

endmodule
